// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a length-prefixed, XOR-checksummed byte
// frame over valid/ready, writes the payload into imem, and releases the core
// only after a frame that passes both the length and checksum checks.
//
// state  | meaning
// IDLE   | out of reset, waiting for load_start_i
// LEN_LO | expecting low byte of payload length
// LEN_HI | expecting high byte of payload length
// DATA   | streaming payload bytes into imem
// CSUM   | expecting the checksum byte (must carry s_last_i)
// DONE   | frame accepted, core released
// ERR    | frame rejected, err_code_o says why
module imem_loader #(
   parameter int                ADDR_W     = 64,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
   parameter int                IMEM_DEPTH = 1024
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              load_start_i,
   input  logic              s_valid_i,
   output logic              s_ready_o,
   input  logic [7:0]        s_data_i,
   input  logic              s_last_i,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [7:0]        imem_wdata_o,
   output logic              cpu_run_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [1:0]        err_code_o,
   output logic [15:0]       byte_cnt_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR
   } state_e;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_LEN   = 2'd1;
   localparam logic [1:0] ERR_CSUM  = 2'd2;
   localparam logic [1:0] ERR_FRAME = 2'd3;

   state_e              state_q, state_d;
   logic [7:0]          len_lo_q, len_lo_d;
   logic [15:0]         len_q, len_d;
   logic [15:0]         idx_q, idx_d;
   logic [7:0]          xor_q, xor_d;
   logic [1:0]          code_q, code_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [7:0]          wdata_q, wdata_d;

   logic                ready;
   logic                accept;
   logic [15:0]         len_new;
   logic [15:0]         idx_inc;

   assign ready   = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                    (state_q == S_DATA)   || (state_q == S_CSUM);
   assign accept  = s_valid_i && ready;
   assign len_new = {s_data_i, len_lo_q};
   assign idx_inc = idx_q + 16'd1;

   // State and datapath registers; everything clears asynchronously on reset.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= S_IDLE;
         len_lo_q <= '0;
         len_q    <= '0;
         idx_q    <= '0;
         xor_q    <= '0;
         code_q   <= ERR_NONE;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         len_lo_q <= len_lo_d;
         len_q    <= len_d;
         idx_q    <= idx_d;
         xor_q    <= xor_d;
         code_q   <= code_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
      end
   end

   // Next-state and datapath update; load_start_i overrides any handshake.
   always_comb begin
      state_d  = state_q;
      len_lo_d = len_lo_q;
      len_d    = len_q;
      idx_d    = idx_q;
      xor_d    = xor_q;
      code_d   = code_q;
      we_d     = 1'b0;
      addr_d   = addr_q;
      wdata_d  = wdata_q;

      if (load_start_i) begin
         state_d = S_LEN_LO;
         len_d   = '0;
         idx_d   = '0;
         xor_d   = '0;
         code_d  = ERR_NONE;
      end else if (accept) begin
         case (state_q)
            S_LEN_LO: begin
               if (s_last_i) begin
                  state_d = S_ERR;
                  code_d  = ERR_FRAME;
               end else begin
                  len_lo_d = s_data_i;
                  state_d  = S_LEN_HI;
               end
            end
            S_LEN_HI: begin
               len_d = len_new;
               if (s_last_i) begin
                  state_d = S_ERR;
                  code_d  = ERR_FRAME;
               end else if (32'(len_new) > 32'(IMEM_DEPTH)) begin
                  state_d = S_ERR;
                  code_d  = ERR_LEN;
               end else if (len_new == 16'd0) begin
                  state_d = S_CSUM;
               end else begin
                  state_d = S_DATA;
               end
            end
            S_DATA: begin
               // A premature last byte is a framing error, not payload.
               if (s_last_i) begin
                  state_d = S_ERR;
                  code_d  = ERR_FRAME;
               end else begin
                  we_d    = 1'b1;
                  addr_d  = BASE_ADDR + ADDR_W'(idx_q);
                  wdata_d = s_data_i;
                  xor_d   = xor_q ^ s_data_i;
                  idx_d   = idx_inc;
                  if (idx_inc == len_q) state_d = S_CSUM;
               end
            end
            S_CSUM: begin
               if (!s_last_i) begin
                  state_d = S_ERR;
                  code_d  = ERR_FRAME;
               end else if (s_data_i != xor_q) begin
                  state_d = S_ERR;
                  code_d  = ERR_CSUM;
               end else begin
                  state_d = S_DONE;
               end
            end
            default: ;
         endcase
      end
   end

   assign s_ready_o    = ready;
   assign busy_o       = ready;
   assign done_o       = (state_q == S_DONE);
   assign cpu_run_o    = (state_q == S_DONE);
   assign err_o        = (state_q == S_ERR);
   assign err_code_o   = code_q;
   assign byte_cnt_o   = idx_q;
   assign imem_we_o    = we_q;
   assign imem_addr_o  = addr_q;
   assign imem_wdata_o = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (base 0 and base 0x100) share stimulus;
// a frame-level reference model predicts writes and final status.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load_start = 1'b0;
   logic        s_valid = 1'b0;
   logic [7:0]  s_data = '0;
   logic        s_last = 1'b0;

   logic        rdy0, we0, run0, busy0, done0, err0;
   logic [63:0] addr0;
   logic [7:0]  wd0;
   logic [1:0]  code0;
   logic [15:0] cnt0;
   logic        rdy1, we1, run1, busy1, done1, err1;
   logic [63:0] addr1;
   logic [7:0]  wd1;
   logic [1:0]  code1;
   logic [15:0] cnt1;

   imem_loader #(.ADDR_W(64), .BASE_ADDR(64'h0), .IMEM_DEPTH(1024)) dut0 (
      .clk_i(clk), .rst_n_i(rst_n), .load_start_i(load_start),
      .s_valid_i(s_valid), .s_ready_o(rdy0), .s_data_i(s_data), .s_last_i(s_last),
      .imem_we_o(we0), .imem_addr_o(addr0), .imem_wdata_o(wd0),
      .cpu_run_o(run0), .busy_o(busy0), .done_o(done0), .err_o(err0),
      .err_code_o(code0), .byte_cnt_o(cnt0));

   imem_loader #(.ADDR_W(64), .BASE_ADDR(64'h100), .IMEM_DEPTH(1024)) dut1 (
      .clk_i(clk), .rst_n_i(rst_n), .load_start_i(load_start),
      .s_valid_i(s_valid), .s_ready_o(rdy1), .s_data_i(s_data), .s_last_i(s_last),
      .imem_we_o(we1), .imem_addr_o(addr1), .imem_wdata_o(wd1),
      .cpu_run_o(run1), .busy_o(busy1), .done_o(done1), .err_o(err1),
      .err_code_o(code1), .byte_cnt_o(cnt1));

   always #5 clk = ~clk;

   int ntests = 0;
   int nfail  = 0;
   int cyc    = 0;
   int we_diff = 0;
   int run_viol = 0;
   bit loading = 1'b0;

   int          w_cyc[$];
   logic [63:0] w_addr0[$];
   logic [63:0] w_addr1[$];
   logic [7:0]  w_data0[$];
   logic [7:0]  w_data1[$];

   logic [7:0]  fb[$];
   bit          fl[$];
   int          m_used;
   int          m_code;
   logic [7:0]  m_wr[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Write capture and invariant watch, sampled just after each rising edge.
   always @(posedge clk) begin
      #1;
      if (we0 === 1'b1) begin
         w_cyc.push_back(cyc);
         w_addr0.push_back(addr0);
         w_data0.push_back(wd0);
         w_addr1.push_back(addr1);
         w_data1.push_back(wd1);
      end
      if (we0 !== we1) we_diff++;
      if (loading && (run0 !== 1'b0 || run1 !== 1'b0)) run_viol++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_writes();
      w_cyc.delete(); w_addr0.delete(); w_addr1.delete();
      w_data0.delete(); w_data1.delete();
   endtask

   // Frame-level reference: what the loader should consume, write and report.
   task automatic model();
      int n;
      logic [7:0] x;
      m_wr.delete();
      m_code = 0;
      if (fl[0]) begin m_used = 1; m_code = 3; return; end
      if (fl[1]) begin m_used = 2; m_code = 3; return; end
      n = int'(fb[0]) + 256 * int'(fb[1]);
      m_used = 2;
      if (n > 1024) begin m_code = 1; return; end
      x = 8'h00;
      for (int i = 0; i < n; i++) begin
         m_used++;
         if (fl[2 + i]) begin m_code = 3; return; end
         m_wr.push_back(fb[2 + i]);
         x = x ^ fb[2 + i];
      end
      m_used++;
      if (!fl[2 + n]) m_code = 3;
      else if (fb[2 + n] != x) m_code = 2;
   endtask

   task automatic build_valid(input int n, input bit corrupt);
      logic [7:0] x, b;
      fb.delete(); fl.delete();
      x = 8'h00;
      fb.push_back(8'(n)); fl.push_back(1'b0);
      fb.push_back(8'(n >> 8)); fl.push_back(1'b0);
      for (int i = 0; i < n; i++) begin
         b = 8'($urandom);
         x = x ^ b;
         fb.push_back(b); fl.push_back(1'b0);
      end
      if (corrupt) x = x ^ 8'(($urandom_range(1, 255)));
      fb.push_back(x); fl.push_back(1'b1);
   endtask

   task automatic start_load();
      @(negedge clk);
      load_start = 1'b1;
      clear_writes();
      @(negedge clk);
      load_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit l, input int gap);
      int wait_cnt;
      repeat (gap) begin
         @(negedge clk);
         s_valid = 1'b0;
      end
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = b;
      s_last  = l;
      wait_cnt = 0;
      while (rdy0 !== 1'b1 && wait_cnt < 50) begin
         @(negedge clk);
         wait_cnt++;
      end
      chk("ready_wait", {63'd0, rdy0}, 64'd1);
      @(posedge clk);
   endtask

   task automatic check_result(input string tag, input bit consec);
      bit ok;
      ok = (m_code == 0);
      chk({tag, "_done"},  {63'd0, done0}, {63'd0, ok});
      chk({tag, "_err"},   {63'd0, err0},  {63'd0, !ok});
      chk({tag, "_code"},  {62'd0, code0}, 64'(m_code));
      chk({tag, "_run"},   {63'd0, run0},  {63'd0, ok});
      chk({tag, "_cnt"},   {48'd0, cnt0},  64'(m_wr.size()));
      chk({tag, "_ready"}, {63'd0, rdy0},  64'd0);
      chk({tag, "_busy"},  {63'd0, busy0}, 64'd0);
      chk({tag, "_done1"}, {61'd0, done1, code1}, {61'd0, ok, 2'(m_code)});
      chk({tag, "_nwr"},   64'(w_cyc.size()), 64'(m_wr.size()));
      for (int i = 0; i < m_wr.size() && i < w_cyc.size(); i++) begin
         chk({tag, "_a0"}, w_addr0[i], 64'(i));
         chk({tag, "_a1"}, w_addr1[i], 64'h100 + 64'(i));
         chk({tag, "_d0"}, {56'd0, w_data0[i]}, {56'd0, m_wr[i]});
         chk({tag, "_d1"}, {56'd0, w_data1[i]}, {56'd0, m_wr[i]});
         if (consec) chk({tag, "_consec"}, 64'(w_cyc[i] - w_cyc[0]), 64'(i));
      end
      chk({tag, "_runviol"}, 64'(run_viol), 64'd0);
      chk({tag, "_wediff"},  64'(we_diff), 64'd0);
   endtask

   task automatic run_frame(input string tag, input bit do_start, input bit gaps);
      model();
      if (do_start) start_load();
      loading = 1'b1;
      for (int i = 0; i < m_used; i++)
         send_byte(fb[i], fl[i], gaps ? int'($urandom_range(1, 3)) : 0);
      loading = 1'b0;
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
      repeat (3) @(negedge clk);
      check_result(tag, !gaps);
   endtask

   initial begin
      int nq;
      #12;
      chk("rst_outs", {we0, addr0, wd0, run0, busy0, done0, err0, code0, cnt0, rdy0} , '0);
      chk("rst_outs1", {we1, addr1, wd1, run1, busy1, done1, err1, code1, cnt1, rdy1}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_ready", {63'd0, rdy0}, 64'd0);

      fb = '{8'h03, 8'h00, 8'h10, 8'h10, 8'h00, 8'h00};
      fl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      run_frame("normal", 1'b1, 1'b0);

      fb = '{8'h02, 8'h00, 8'h30, 8'hF2, 8'h00};
      fl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      run_frame("csum", 1'b1, 1'b0);

      fb = '{8'h01, 8'h04};
      fl = '{1'b0, 1'b0};
      run_frame("ovf", 1'b1, 1'b0);

      fb = '{8'h00, 8'h00, 8'h00};
      fl = '{1'b0, 1'b0, 1'b1};
      run_frame("empty", 1'b1, 1'b0);

      fb = '{8'h03, 8'h00, 8'h10, 8'h10, 8'h00, 8'h00};
      fl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      run_frame("bp", 1'b1, 1'b1);

      fb = '{8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
      fl = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      run_frame("frame", 1'b1, 1'b0);

      fb = '{8'h01, 8'h00, 8'h5A, 8'h5A};
      fl = '{1'b0, 1'b0, 1'b0, 1'b0};
      run_frame("nolast", 1'b1, 1'b0);

      fb = '{8'h00, 8'h04};
      fl = '{1'b0, 1'b0};
      build_valid(1024, 1'b0);
      run_frame("maxlen", 1'b1, 1'b0);

      for (int k = 0; k < 4; k++) begin
         build_valid(int'($urandom_range(1, 24)), k[0]);
         run_frame("rand", 1'b1, k[1]);
      end

      // Restart mid-load; the byte offered with load_start must be dropped.
      build_valid(3, 1'b0);
      start_load();
      loading = 1'b1;
      for (int i = 0; i < 3; i++) send_byte(fb[i], fl[i], 0);
      @(negedge clk);
      load_start = 1'b1;
      s_data = fb[3];
      s_valid = 1'b1;
      clear_writes();
      @(negedge clk);
      load_start = 1'b0;
      s_valid = 1'b0;
      chk("rs_flags", {58'd0, done0, err0, code0, run0, busy0}, {58'd0, 6'b000001});
      chk("rs_ready", {63'd0, rdy0}, 64'd1);
      chk("rs_cnt", {48'd0, cnt0}, 64'd0);
      chk("rs_nowr", 64'(w_cyc.size()), 64'd0);
      build_valid(5, 1'b0);
      run_frame("after_rs", 1'b0, 1'b0);

      // Asynchronous reset in the middle of DATA.
      build_valid(8, 1'b0);
      start_load();
      loading = 1'b1;
      for (int i = 0; i < 5; i++) send_byte(fb[i], fl[i], 0);
      #3;
      rst_n = 1'b0;
      #1;
      loading = 1'b0;
      chk("mr_outs", {we0, addr0, wd0, run0, busy0, done0, err0, code0, cnt0, rdy0}, '0);
      chk("mr_outs1", {we1, addr1, wd1, run1, busy1, done1, err1, code1, cnt1, rdy1}, '0);
      nq = w_cyc.size();
      chk("mr_prewr", 64'(nq), 64'd3);
      repeat (4) @(negedge clk);
      chk("mr_nowr", 64'(w_cyc.size()), 64'(nq));
      rst_n = 1'b1;
      s_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mr_idle", {61'd0, rdy0, busy0, done0}, 64'd0);
      chk("mr_nowr2", 64'(w_cyc.size()), 64'(nq));

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
